branch_ctrl_seq: RTL and testbench
==================================

// Module: branch_ctrl_seq
// PURPOSE
//  Hardwired control-step sequencer for the single-bus DataPath. Generates the fetch (T0-T2) and
//  control-transfer (br/jr/jal) step signals that testbenches currently drive by hand.
//  Adds programmable RAM wait states, back-to-back instruction issue and a taken-branch counter.
//  It sits beside DataPath. Its outputs connect 1:1 to DataPath control inputs of the same name.
// PARAMETERS
//  DATA_W    32        IR width; opcode = ir[DATA_W-1 -: 5]
//  MEM_WAIT  0         extra cycles T1 is held for RAM read (0..15)
//  CNT_W     16        width of taken_count
//  OP_BR     5'b10010  conditional branch opcode
//  OP_JR     5'b10100  jump-register opcode
//  OP_JAL    5'b10011  jump-and-link opcode (link reg R15)
// PORTS
//  clock        in   1       rising-edge clock
//  clear        in   1       synchronous active-high reset
//  run          in   1       level; start/continue issuing instructions
//  ir           in   DATA_W  IR contents (valid from T3)
//  con_ff       in   1       CON FF output from DataPath
//  PCout,IncPC,MARin,read,RAMenable,MDRin,MDRout,IRin  out 1 each  fetch controls
//  Gra,Rout,conin,Yin,Cout,ZLOin,ZLOout,PCin,R15in      out 1 each  execute controls
//  aluControl   out  5       ALU op; 5'b00011 (ADD) in branch T5, else 5'b00000
//  state        out  4       current step, for debug
//  busy         out  1       high in any state other than IDLE
//  taken        out  1       1-cycle pulse on a taken br or any jr/jal PC load
//  illegal      out  1       1-cycle pulse at T3 on an unsupported opcode
//  taken_count  out  CNT_W   count of taken pulses; wraps to 0
// BEHAVIOUR
//  - State register updates on posedge clock. All controls are a Moore decode of the state.
//    A control is asserted for exactly the full cycle(s) of its state.
//  - States: IDLE=0,T0=1,T1=2,T2=3,T3=4,T4=5,T5=6,T6=7.
//  - IDLE: all outputs 0. Go to T0 when run=1.
//  - T0: PCout,MARin,IncPC.
//  - T1: read,RAMenable held for MEM_WAIT+1 cycles, via a wait counter loaded on T0->T1.
//    MDRin is asserted only on the last T1 cycle.
//  - T2: MDRout,IRin.
//  - T3 by opcode:
//    - BR: Gra,Rout,conin -> T4.
//    - JR: Gra,Rout,PCin, taken=1 -> end.
//    - JAL: PCout,R15in -> T4.
//    - Other: illegal=1 -> end.
//  - T4:
//    - BR: PCout,Yin -> T5.
//    - JAL: Gra,Rout,PCin, taken=1 -> end.
//  - T5 (BR only): Cout, aluControl=00011, ZLOin -> T6.
//  - T6 (BR only): con_ff is sampled this cycle.
//    - If con_ff=1: ZLOout,PCin, taken=1.
//    - If con_ff=0: no controls (PC keeps PC+1).
//    - Then -> end.
//  - "end": go to T0 if run=1, with no idle cycle between instructions. Otherwise go to IDLE.
//  - run deasserted mid-instruction: the current instruction completes. Only issue of the next one stops.
//  - taken_count increments on every cycle with taken=1. At 2^CNT_W-1 it wraps to 0.
//  - clear: at the next posedge, state=IDLE, wait counter=0, taken_count=0, all outputs 0.
//    clear overrides run and aborts any instruction in progress. No partial PCin is issued after clear.
//  - Exactly one of {PCout, Rout, MDRout, ZLOout, Cout} is high in any cycle, or none. Never two (bus contention).
// TESTING
//  1. clear, run=1, MEM_WAIT=0, ir op=BR, con_ff=1
//     -> states 1..7 one cycle each; T5 aluControl=00011; T6 ZLOout&PCin; taken pulse; taken_count=1.
//  2. Same as 1 with con_ff=0 at T6 -> no PCin in T6; taken=0; count unchanged; next T0 follows T6 directly.
//  3. MEM_WAIT=3 -> read/RAMenable high for 4 cycles; MDRin high only in 4th; total fetch 6 cycles.
//  4. JAL then JR back-to-back:
//     - JAL: T3 PCout&R15in; T4 PCin.
//     - JR: T3 PCin.
//     - count +2; run=0 after JR -> IDLE, busy=0.
//  5. op=5'b11111 -> illegal pulse at T3; no PCin; sequencer returns to T0.
//     clear asserted in T5 of a BR -> IDLE next cycle, count=0.
//  6. Force taken_count to 2^CNT_W-1 (CNT_W=2, 3 taken branches), then 1 more -> wraps to 0.
//     Assertion check each cycle: at most one bus driver high.

Source files
------------

// File: rtl/branch_ctrl_seq_if.sv
// rtl/branch_ctrl_seq_if.sv - control bundle between the step sequencer and the single-bus DataPath
//
// master: sequencer side (takes run/ir/con_ff, drives every DataPath control and status)
// slave : DataPath / environment side (drives run/ir/con_ff, observes controls)
interface branch_ctrl_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              run;
    logic [DATA_W-1:0] ir;
    logic              con_ff;

    logic PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin;
    logic Gra, Rout, conin, Yin, Cout, ZLOin, ZLOout, PCin, R15in;

    logic [4:0]       aluControl;
    logic [3:0]       state;
    logic             busy;
    logic             taken;
    logic             illegal;
    logic [CNT_W-1:0] taken_count;

    modport master (
        input  run, ir, con_ff,
        output PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
        output Gra, Rout, conin, Yin, Cout, ZLOin, ZLOout, PCin, R15in,
        output aluControl, state, busy, taken, illegal, taken_count
    );

    modport slave (
        output run, ir, con_ff,
        input  PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
        input  Gra, Rout, conin, Yin, Cout, ZLOin, ZLOout, PCin, R15in,
        input  aluControl, state, busy, taken, illegal, taken_count
    );
endinterface

// File: rtl/branch_ctrl_seq.sv
// rtl/branch_ctrl_seq.sv - hardwired fetch / br / jr / jal control-step sequencer
//
// Ports:
//   clock : rising-edge clock
//   clear : synchronous active-high reset (state, wait counter, taken counter)
//   bus   : branch_ctrl_seq_if.master - run/ir/con_ff in; DataPath controls,
//           aluControl, state, busy, taken, illegal, taken_count out
module branch_ctrl_seq #(
    parameter int         DATA_W   = 32,
    parameter int         MEM_WAIT = 0,
    parameter int         CNT_W    = 16,
    parameter logic [4:0] OP_BR    = 5'b10010,
    parameter logic [4:0] OP_JR    = 5'b10100,
    parameter logic [4:0] OP_JAL   = 5'b10011
) (
    input  logic            clock,
    input  logic            clear,
    branch_ctrl_seq_if.master bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;

    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [3:0] WAIT_LD  = 4'(MEM_WAIT);

    logic [3:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] opcode;
    logic       is_br, is_jr, is_jal;
    logic       unused_ir;
    logic [3:0] end_state;

    assign opcode    = bus.ir[DATA_W-1 -: 5];
    assign unused_ir = ^bus.ir[DATA_W-6:0];
    assign is_br     = (opcode == OP_BR);
    assign is_jr     = (opcode == OP_JR);
    assign is_jal    = (opcode == OP_JAL);

    // Instruction end: issue the next fetch immediately while run holds.
    assign end_state = bus.run ? S_T0 : S_IDLE;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = WAIT_LD;
            end
            S_T1: begin
                if (wait_q == 4'd0) state_d = S_T2;
                else                wait_d  = wait_q - 4'd1;
            end
            S_T2:    state_d = S_T3;
            S_T3:    state_d = (is_br || is_jal) ? S_T4 : end_state;
            S_T4:    state_d = is_br ? S_T5 : end_state;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = end_state;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.MARin      = 1'b0;
        bus.read       = 1'b0;
        bus.RAMenable  = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Gra        = 1'b0;
        bus.Rout       = 1'b0;
        bus.conin      = 1'b0;
        bus.Yin        = 1'b0;
        bus.Cout       = 1'b0;
        bus.ZLOin      = 1'b0;
        bus.ZLOout     = 1'b0;
        bus.PCin       = 1'b0;
        bus.R15in      = 1'b0;
        bus.aluControl = 5'b00000;
        bus.taken      = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            S_T1: begin
                bus.read      = 1'b1;
                bus.RAMenable = 1'b1;
                // Latch MDR only once the RAM has had its full access time.
                bus.MDRin     = (wait_q == 4'd0);
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_br) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.conin = 1'b1;
                end else if (is_jr) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.PCin  = 1'b1;
                    bus.taken = 1'b1;
                end else if (is_jal) begin
                    bus.PCout = 1'b1;
                    bus.R15in = 1'b1;
                end else begin
                    bus.illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_br) begin
                    bus.PCout = 1'b1;
                    bus.Yin   = 1'b1;
                end else if (is_jal) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.PCin  = 1'b1;
                    bus.taken = 1'b1;
                end
            end
            S_T5: begin
                bus.Cout       = 1'b1;
                bus.ZLOin      = 1'b1;
                bus.aluControl = ALU_ADD;
            end
            S_T6: begin
                // Not taken: PC already holds PC+1 from T0, so nothing to do.
                if (bus.con_ff) begin
                    bus.ZLOout = 1'b1;
                    bus.PCin   = 1'b1;
                    bus.taken  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cnt_d           = cnt_q + {{(CNT_W-1){1'b0}}, bus.taken};
    assign bus.state       = state_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.taken_count = cnt_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_ctrl_seq.sv
// tb/tb_branch_ctrl_seq.sv - self-checking bench for branch_ctrl_seq
module tb_branch_ctrl_seq;
    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JR  = 5'b10100;
    localparam logic [4:0] OP_JAL = 5'b10011;

    // control vector bit positions
    localparam int B_PCOUT = 16, B_INCPC = 15, B_MARIN = 14, B_READ = 13, B_RAMEN = 12;
    localparam int B_MDRIN = 11, B_MDROUT = 10, B_IRIN = 9, B_GRA = 8, B_ROUT = 7;
    localparam int B_CONIN = 6, B_YIN = 5, B_COUT = 4, B_ZLOIN = 3, B_ZLOOUT = 2;
    localparam int B_PCIN = 1, B_R15IN = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [4:0]  alu;
        logic        tk;
        logic        il;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        con_ff = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        sel = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    branch_ctrl_seq_if #(.DATA_W(32), .CNT_W(2))  ifa();
    branch_ctrl_seq_if #(.DATA_W(32), .CNT_W(16)) ifb();

    assign ifa.run = run;  assign ifa.ir = ir;  assign ifa.con_ff = con_ff;
    assign ifb.run = run;  assign ifb.ir = ir;  assign ifb.con_ff = con_ff;

    branch_ctrl_seq #(.DATA_W(32), .MEM_WAIT(0), .CNT_W(2)) dut_a (
        .clock(clock), .clear(clear), .bus(ifa.master));
    branch_ctrl_seq #(.DATA_W(32), .MEM_WAIT(3), .CNT_W(16)) dut_b (
        .clock(clock), .clear(clear), .bus(ifb.master));

    wire [16:0] ctl_a = {ifa.PCout, ifa.IncPC, ifa.MARin, ifa.read, ifa.RAMenable, ifa.MDRin,
                         ifa.MDRout, ifa.IRin, ifa.Gra, ifa.Rout, ifa.conin, ifa.Yin, ifa.Cout,
                         ifa.ZLOin, ifa.ZLOout, ifa.PCin, ifa.R15in};
    wire [16:0] ctl_b = {ifb.PCout, ifb.IncPC, ifb.MARin, ifb.read, ifb.RAMenable, ifb.MDRin,
                         ifb.MDRout, ifb.IRin, ifb.Gra, ifb.Rout, ifb.conin, ifb.Yin, ifb.Cout,
                         ifb.ZLOin, ifb.ZLOout, ifb.PCin, ifb.R15in};

    wire [16:0] o_ctl   = sel ? ctl_b : ctl_a;
    wire [3:0]  o_state = sel ? ifb.state : ifa.state;
    wire [4:0]  o_alu   = sel ? ifb.aluControl : ifa.aluControl;
    wire        o_busy  = sel ? ifb.busy : ifa.busy;
    wire        o_taken = sel ? ifb.taken : ifa.taken;
    wire        o_ill   = sel ? ifb.illegal : ifa.illegal;
    wire [15:0] o_cnt   = sel ? ifb.taken_count : {14'd0, ifa.taken_count};
    wire [4:0]  o_drv   = {o_ctl[B_PCOUT], o_ctl[B_ROUT], o_ctl[B_MDROUT], o_ctl[B_ZLOOUT], o_ctl[B_COUT]};

    function automatic int mem_wait();
        return sel ? 3 : 0;
    endfunction

    function automatic int cnt_mod();
        return sel ? 65536 : 4;
    endfunction

    function automatic void push(input int st, input logic [16:0] ctl, input logic [4:0] alu,
                                 input logic tk, input logic il);
        exp_t e;
        e.st = 4'(st); e.ctl = ctl; e.alu = alu; e.tk = tk; e.il = il;
        exp_q.push_back(e);
    endfunction

    function automatic logic [16:0] m(input int b);
        return 17'(1) << b;
    endfunction

    // Reference step trace for one instruction, straight from the step table.
    function automatic void build(input logic [4:0] op, input logic con);
        exp_q.delete();
        push(1, m(B_PCOUT) | m(B_INCPC) | m(B_MARIN), 5'd0, 1'b0, 1'b0);
        for (int i = 0; i <= mem_wait(); i++)
            push(2, m(B_READ) | m(B_RAMEN) | ((i == mem_wait()) ? m(B_MDRIN) : 17'd0), 5'd0, 1'b0, 1'b0);
        push(3, m(B_MDROUT) | m(B_IRIN), 5'd0, 1'b0, 1'b0);
        if (op == OP_BR) begin
            push(4, m(B_GRA) | m(B_ROUT) | m(B_CONIN), 5'd0, 1'b0, 1'b0);
            push(5, m(B_PCOUT) | m(B_YIN), 5'd0, 1'b0, 1'b0);
            push(6, m(B_COUT) | m(B_ZLOIN), 5'b00011, 1'b0, 1'b0);
            push(7, con ? (m(B_ZLOOUT) | m(B_PCIN)) : 17'd0, 5'd0, con, 1'b0);
        end else if (op == OP_JR) begin
            push(4, m(B_GRA) | m(B_ROUT) | m(B_PCIN), 5'd0, 1'b1, 1'b0);
        end else if (op == OP_JAL) begin
            push(4, m(B_PCOUT) | m(B_R15IN), 5'd0, 1'b0, 1'b0);
            push(5, m(B_GRA) | m(B_ROUT) | m(B_PCIN), 5'd0, 1'b1, 1'b0);
        end else begin
            push(4, 17'd0, 5'd0, 1'b0, 1'b1);
        end
    endfunction

    // Runs one instruction (run must already be 1), comparing every cycle with the trace.
    // abort_at >= 0 raises clear in that cycle and stops following the trace.
    task automatic run_instr(input logic [4:0] op, input logic con, input logic keep_run,
                             input int abort_at);
        exp_t e;
        build(op, con);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            e = exp_q[i];
            checks++;
            if (o_state !== e.st) begin
                failures++;
                $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, i, o_state, e.st);
            end
            checks++;
            if (o_ctl !== e.ctl) begin
                failures++;
                $display("FAIL controls op=%b cyc=%0d got=%b exp=%b", op, i, o_ctl, e.ctl);
            end
            checks++;
            if ({o_alu, o_taken, o_ill, o_busy} !== {e.alu, e.tk, e.il, 1'b1}) begin
                failures++;
                $display("FAIL alu_tk_ill_busy op=%b cyc=%0d got=%b exp=%b", op, i,
                         {o_alu, o_taken, o_ill, o_busy}, {e.alu, e.tk, e.il, 1'b1});
            end
            checks++;
            if (o_cnt !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL taken_count cyc=%0d got=%0d exp=%0d", i, o_cnt, exp_cnt);
            end
            checks++;
            if ($countones(o_drv) > 1) begin
                failures++;
                $display("FAIL bus_contention cyc=%0d drivers=%b exp=at_most_one", i, o_drv);
            end
            if (e.tk) exp_cnt = (exp_cnt + 1) % cnt_mod();
            if (i == 0) begin
                ir     = {op, 27'($urandom)};
                con_ff = con;
            end
            if (i == abort_at) begin
                clear = 1'b1;
                break;
            end
            if (i == exp_q.size() - 1) run = keep_run;
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clock);
        checks++;
        if ({o_state, o_busy, o_ctl, o_taken, o_ill} !== 24'd0) begin
            failures++;
            $display("FAIL %s idle got state=%0d busy=%b ctl=%b exp state=0 busy=0 ctl=0",
                     tag, o_state, o_busy, o_ctl);
        end
        checks++;
        if (o_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL %s count got=%0d exp=%0d", tag, o_cnt, exp_cnt);
        end
    endtask

    task automatic do_clear(input logic which);
        @(negedge clock);
        sel   = which;
        run   = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        do_clear(1'b0);
        expect_idle("reset_a");
        do_clear(1'b1);
        expect_idle("reset_b");
    endtask

    task automatic test_br_taken();
        do_clear(1'b0);
        run = 1'b1;
        run_instr(OP_BR, 1'b1, 1'b0, -1);
        expect_idle("br_taken_end");
    endtask

    task automatic test_br_not_taken();
        do_clear(1'b0);
        run = 1'b1;
        run_instr(OP_BR, 1'b0, 1'b1, -1);
        run_instr(OP_JR, 1'b0, 1'b0, -1);
        expect_idle("br_not_taken_end");
    endtask

    task automatic test_mem_wait();
        do_clear(1'b1);
        run = 1'b1;
        run_instr(OP_BR, 1'b1, 1'b1, -1);
        run_instr(OP_JAL, 1'b0, 1'b0, -1);
        expect_idle("mem_wait_end");
    endtask

    task automatic test_back_to_back();
        do_clear(1'b0);
        run = 1'b1;
        run_instr(OP_JAL, 1'b0, 1'b1, -1);
        run_instr(OP_JR, 1'b0, 1'b0, -1);
        expect_idle("jal_jr_end");
    endtask

    task automatic test_illegal();
        do_clear(1'b0);
        run = 1'b1;
        run_instr(5'b11111, 1'b1, 1'b1, -1);
        run_instr(OP_BR, 1'b1, 1'b0, -1);
        expect_idle("illegal_end");
    endtask

    task automatic test_clear_abort();
        do_clear(1'b0);
        run = 1'b1;
        run_instr(OP_JR, 1'b0, 1'b1, -1);
        run_instr(OP_BR, 1'b1, 1'b1, 5);
        exp_cnt = 0;
        expect_idle("clear_abort_1");
        expect_idle("clear_abort_2");
        clear = 1'b0;
        run   = 1'b0;
        expect_idle("clear_abort_3");
    endtask

    task automatic test_wrap();
        do_clear(1'b0);
        run = 1'b1;
        for (int k = 0; k < 3; k++) run_instr(OP_BR, 1'b1, 1'b1, -1);
        run_instr(OP_BR, 1'b1, 1'b0, -1);
        expect_idle("wrap_end");
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic       keep;
        for (int r = 0; r < 4; r++) begin
            do_clear(1'($urandom));
            run = 1'b1;
            for (int n = 0; n < 12; n++) begin
                case ($urandom_range(0, 3))
                    0: op = OP_BR;
                    1: op = OP_JR;
                    2: op = OP_JAL;
                    default: begin
                        op = 5'($urandom);
                        if (op == OP_BR || op == OP_JR || op == OP_JAL) op = 5'b00000;
                    end
                endcase
                keep = ($urandom_range(0, 3) != 0);
                run_instr(op, 1'($urandom), keep, -1);
                if (!keep) begin
                    expect_idle("random_idle");
                    run = 1'b1;
                end
            end
            run = 1'b0;
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_br_taken();
        test_br_not_taken();
        test_mem_wait();
        test_back_to_back();
        test_illegal();
        test_clear_abort();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
